// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB power-up configuration sequencer.
package sccb_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DELAY = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } seq_state_e;

    localparam logic [15:0] END_MARK         = 16'hFFFF;
    localparam logic [7:0]  DELAY_TAG        = 8'hF0;
    localparam logic [7:0]  DEFAULT_SLAVE_ID = 8'h42;

    // A table entry whose upper byte is the delay tag is a pause, not a bus write.
    function automatic logic is_delay_tag(input logic [7:0] hi_byte);
        return (hi_byte == DELAY_TAG);
    endfunction

endpackage

// File: rtl/sccb_cfg_rom.sv
// Configuration table: ROM_DEPTH x 16 entries with a registered read port.
module sccb_cfg_rom
    import sccb_pkg::*;
#(
    parameter int                      ROM_DEPTH = 64,
    parameter logic [ROM_DEPTH*16-1:0] ROM_INIT  = {ROM_DEPTH{END_MARK}}
) (
    input  logic        clk,
    input  logic [5:0]  addr,
    output logic [15:0] data
);

    logic [15:0] tbl_s [64];
    logic [15:0] data_r;

    // Slots beyond the populated depth read back as the end marker.
    for (genvar i = 0; i < 64; i++) begin : g_tbl
        if (i < ROM_DEPTH) begin : g_used
            assign tbl_s[i] = ROM_INIT[i*16 +: 16];
        end else begin : g_pad
            assign tbl_s[i] = END_MARK;
        end
    end

    // Synchronous table read.
    always_ff @(posedge clk) begin
        data_r <= tbl_s[addr];
    end

    assign data = data_r;

endmodule

// File: rtl/sccb_cfg_sequencer.sv
// Walks the configuration table after start, issuing SCCB writes and ms delays,
// with per-entry NACK retries and a completion timeout.
module sccb_cfg_sequencer
    import sccb_pkg::*;
#(
    parameter int                      ROM_DEPTH      = 64,
    parameter logic [7:0]              SLAVE_ID       = DEFAULT_SLAVE_ID,
    parameter int                      MS_CYCLES      = 10000,
    parameter int                      MAX_RETRY      = 3,
    parameter int                      TIMEOUT_CYCLES = 65535,
    parameter logic [ROM_DEPTH*16-1:0] ROM_INIT       = {ROM_DEPTH{END_MARK}}
) (
    input  logic       SYSCLK,
    input  logic       SYSRESET,
    input  logic       start,
    output logic       wr_req,
    output logic [7:0] wr_id,
    output logic [7:0] wr_reg,
    output logic [7:0] wr_data,
    input  logic       wr_busy,
    input  logic       wr_done,
    input  logic       wr_nack,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [5:0] err_index
);

    localparam int         TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam int         DW       = $clog2(255 * MS_CYCLES + 1);
    localparam int         RW       = $clog2(MAX_RETRY + 2);
    localparam logic [5:0] LAST_IDX = 6'(ROM_DEPTH - 1);

    seq_state_e    state_r, state_nxt_s;
    logic          fetch_ph_r;
    logic [5:0]    idx_r;
    logic          past_end_r;
    logic [RW-1:0] retry_r;
    logic [TW-1:0] wait_cnt_r;
    logic [DW-1:0] dly_cnt_r;
    logic [15:0]   entry_r;
    logic [15:0]   rom_data_s;
    logic          go_s, advance_s, retry_s, fire_s, decode_s;
    logic          wr_req_r, busy_r, done_r, error_r;
    logic [7:0]    wr_id_r, wr_reg_r, wr_data_r;
    logic [5:0]    err_index_r;

    sccb_cfg_rom #(
        .ROM_DEPTH (ROM_DEPTH),
        .ROM_INIT  (ROM_INIT)
    ) u_rom (
        .clk  (SYSCLK),
        .addr (idx_r),
        .data (rom_data_s)
    );

    assign decode_s = (state_r == S_FETCH) && fetch_ph_r;

    // Next-state and single-cycle control strobes.
    always_comb begin
        state_nxt_s = state_r;
        go_s        = 1'b0;
        advance_s   = 1'b0;
        retry_s     = 1'b0;
        fire_s      = 1'b0;
        case (state_r)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_nxt_s = S_FETCH;
                    go_s        = 1'b1;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_FETCH: begin
                if (!fetch_ph_r) begin
                    state_nxt_s = S_FETCH;
                end else if (past_end_r || (rom_data_s == END_MARK)) begin
                    state_nxt_s = S_DONE;
                end else if (is_delay_tag(rom_data_s[15:8])) begin
                    state_nxt_s = S_DELAY;
                end else begin
                    state_nxt_s = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (wr_busy) begin
                    state_nxt_s = S_ISSUE;
                end else begin
                    state_nxt_s = S_WAIT;
                    fire_s      = 1'b1;
                end
            end
            S_WAIT: begin
                // A completion on the final timeout cycle still counts.
                if (wr_done) begin
                    if (!wr_nack) begin
                        state_nxt_s = S_FETCH;
                        advance_s   = 1'b1;
                    end else if (retry_r < RW'(MAX_RETRY)) begin
                        state_nxt_s = S_ISSUE;
                        retry_s     = 1'b1;
                    end else begin
                        state_nxt_s = S_ERROR;
                    end
                end else if (wait_cnt_r == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt_s = S_ERROR;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            S_DELAY: begin
                if (dly_cnt_r <= DW'(1)) begin
                    state_nxt_s = S_FETCH;
                    advance_s   = 1'b1;
                end else begin
                    state_nxt_s = S_DELAY;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge SYSCLK) begin
        if (SYSRESET) begin
            state_r     <= S_IDLE;
            fetch_ph_r  <= 1'b0;
            idx_r       <= 6'd0;
            past_end_r  <= 1'b0;
            retry_r     <= '0;
            wait_cnt_r  <= '0;
            dly_cnt_r   <= '0;
            entry_r     <= 16'h0000;
            wr_req_r    <= 1'b0;
            wr_id_r     <= 8'h00;
            wr_reg_r    <= 8'h00;
            wr_data_r   <= 8'h00;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
            err_index_r <= 6'd0;
        end else begin
            state_r    <= state_nxt_s;
            fetch_ph_r <= (state_r == S_FETCH) && !fetch_ph_r;

            // The index saturates; stepping past the last slot raises past_end_r instead.
            if (go_s) begin
                idx_r      <= 6'd0;
                past_end_r <= 1'b0;
            end else if (advance_s) begin
                if (idx_r == LAST_IDX) begin
                    past_end_r <= 1'b1;
                end else begin
                    idx_r <= idx_r + 6'd1;
                end
            end

            if (go_s || advance_s) begin
                retry_r <= '0;
            end else if (retry_s) begin
                retry_r <= retry_r + RW'(1);
            end

            if ((state_r == S_WAIT) && (state_nxt_s == S_WAIT)) begin
                wait_cnt_r <= wait_cnt_r + TW'(1);
            end else begin
                wait_cnt_r <= '0;
            end

            if (decode_s) begin
                entry_r   <= rom_data_s;
                dly_cnt_r <= DW'(rom_data_s[7:0]) * DW'(MS_CYCLES);
            end else if ((state_r == S_DELAY) && (dly_cnt_r != '0)) begin
                dly_cnt_r <= dly_cnt_r - DW'(1);
            end

            // Write fields change only when a request is launched, so they stay put until wr_done.
            wr_req_r <= fire_s;
            if (fire_s) begin
                wr_id_r   <= SLAVE_ID;
                wr_reg_r  <= entry_r[15:8];
                wr_data_r <= entry_r[7:0];
            end

            busy_r  <= (state_nxt_s == S_FETCH) || (state_nxt_s == S_ISSUE) ||
                       (state_nxt_s == S_WAIT)  || (state_nxt_s == S_DELAY);
            done_r  <= (state_nxt_s == S_DONE);
            error_r <= (state_nxt_s == S_ERROR);
            if ((state_nxt_s == S_ERROR) && (state_r != S_ERROR)) begin
                err_index_r <= idx_r;
            end
        end
    end

    assign wr_req    = wr_req_r;
    assign wr_id     = wr_id_r;
    assign wr_reg    = wr_reg_r;
    assign wr_data   = wr_data_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign error     = error_r;
    assign err_index = err_index_r;

endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
// Self-checking bench: table-driven master responses with a write scoreboard,
// plus hand-written timeout, reset-abort and busy/restart sequences.
module tb_sccb_cfg_sequencer;

    localparam int         TMO    = 1000;
    localparam logic [7:0] EXP_ID = 8'h42;
    // Entries 0..6: four writes, a 2 ms delay, one write, end marker.
    localparam logic [64*16-1:0] TBL = {{57{16'hFFFF}}, 16'hFFFF, 16'h9ABC, 16'hF002,
                                        16'h7788, 16'h5666, 16'h3455, 16'h1280};

    typedef struct {
        int         lat;
        bit         nack;
        logic [7:0] reg_f;
        logic [7:0] data_f;
    } vec_t;

    typedef struct packed {
        logic [7:0] reg_f;
        logic [7:0] data_f;
    } exp_t;

    logic       clk, rst, start, wr_busy, wr_done, wr_nack;
    logic       wr_req, busy, done, error;
    logic [7:0] wr_id, wr_reg, wr_data;
    logic [5:0] err_index;

    exp_t        exp_q[$];
    exp_t        exp_e;
    logic [23:0] held;
    int          n_pass, n_total, cyc, req_cnt;
    vec_t        vec_a[5];
    vec_t        vec_b[9];

    sccb_cfg_sequencer #(
        .TIMEOUT_CYCLES (TMO),
        .ROM_INIT       (TBL)
    ) dut (
        .SYSCLK    (clk),
        .SYSRESET  (rst),
        .start     (start),
        .wr_req    (wr_req),
        .wr_id     (wr_id),
        .wr_reg    (wr_reg),
        .wr_data   (wr_data),
        .wr_busy   (wr_busy),
        .wr_done   (wr_done),
        .wr_nack   (wr_nack),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_index (err_index)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Scoreboard monitor: every wr_req must match the next queued write.
    always @(negedge clk) begin
        #1;
        if (!rst && wr_req) begin
            req_cnt++;
            held = {wr_id, wr_reg, wr_data};
            if (exp_q.size() == 0) begin
                chk("unexpected_wr_req", 32'(wr_req), 32'd0);
            end else begin
                exp_e = exp_q.pop_front();
                chk("wr_id", 32'(wr_id), 32'(EXP_ID));
                chk("wr_reg", 32'(wr_reg), 32'(exp_e.reg_f));
                chk("wr_data", 32'(wr_data), 32'(exp_e.data_f));
            end
        end
        if (!rst && wr_done) chk("fields_stable", 32'({wr_id, wr_reg, wr_data}), 32'(held));
    end

    task automatic wait_req(output bit ok, output int at);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < 30000; i++) begin
            @(negedge clk);
            if (wr_req) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
        chk("wr_req_seen", 32'(ok), 32'd1);
    endtask

    task automatic serve(input int lat, input bit nack, output int req_at, output int done_at);
        bit ok;
        wait_req(ok, req_at);
        done_at = cyc;
        if (ok) begin
            repeat (lat) @(negedge clk);
            wr_done = 1'b1;
            wr_nack = nack;
            done_at = cyc;
            @(negedge clk);
            wr_done = 1'b0;
            wr_nack = 1'b0;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done || error) begin
                seen = 1'b1;
                break;
            end
        end
        chk("end_state_reached", 32'(seen), 32'd1);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_wr_req"}, 32'(wr_req), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_fields"}, 32'({wr_id, wr_reg, wr_data}), 32'd0);
        chk({tag, "_err_index"}, 32'(err_index), 32'd0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int req_c[5];
        int done_c[5];
        int r0, d0, gap, rc0;
        bit ok;

        clk = 1'b0; rst = 1'b1; start = 1'b0;
        wr_busy = 1'b0; wr_done = 1'b0; wr_nack = 1'b0;
        n_pass = 0; n_total = 0; cyc = 0; req_cnt = 0; held = 24'h0;

        vec_a[0] = '{4, 1'b0, 8'h12, 8'h80};
        vec_a[1] = '{4, 1'b0, 8'h34, 8'h55};
        vec_a[2] = '{4, 1'b0, 8'h56, 8'h66};
        vec_a[3] = '{4, 1'b0, 8'h77, 8'h88};
        vec_a[4] = '{4, 1'b0, 8'h9A, 8'hBC};

        vec_b[0] = '{2, 1'b1, 8'h12, 8'h80};
        vec_b[1] = '{3, 1'b1, 8'h12, 8'h80};
        vec_b[2] = '{5, 1'b1, 8'h12, 8'h80};
        vec_b[3] = '{1, 1'b0, 8'h12, 8'h80};
        vec_b[4] = '{6, 1'b0, 8'h34, 8'h55};
        vec_b[5] = '{0, 1'b1, 8'h56, 8'h66};
        vec_b[6] = '{2, 1'b1, 8'h56, 8'h66};
        vec_b[7] = '{4, 1'b1, 8'h56, 8'h66};
        vec_b[8] = '{3, 1'b1, 8'h56, 8'h66};

        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Full pass with all writes acknowledged, including the 2 ms delay entry.
        pulse_start();
        chk("busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({vec_a[i].reg_f, vec_a[i].data_f});
            serve(vec_a[i].lat, vec_a[i].nack, req_c[i], done_c[i]);
        end
        gap = req_c[4] - done_c[3];
        n_total++;
        if (gap >= 20000 && gap <= 20010) n_pass++;
        else $display("FAIL delay_gap: got %0d cycles, expected 20000..20010", gap);
        wait_end();
        chk("a_done", 32'(done), 32'd1);
        chk("a_error", 32'(error), 32'd0);
        chk("a_busy", 32'(busy), 32'd0);
        chk("a_queue_empty", 32'(exp_q.size()), 32'd0);

        // Three NACKs then ACK continue; four NACKs on entry 2 end in error.
        pulse_start();
        chk("b_done_cleared", 32'(done), 32'd0);
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back({vec_b[i].reg_f, vec_b[i].data_f});
            serve(vec_b[i].lat, vec_b[i].nack, r0, d0);
        end
        wait_end();
        chk("b_error", 32'(error), 32'd1);
        chk("b_err_index", 32'(err_index), 32'd2);
        chk("b_done", 32'(done), 32'd0);
        chk("b_busy", 32'(busy), 32'd0);
        chk("b_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (5) @(negedge clk);
        chk("b_error_held", 32'(error), 32'd1);

        // wr_done withheld on entry 1: error exactly after the timeout window.
        pulse_start();
        chk("c_error_cleared", 32'(error), 32'd0);
        exp_q.push_back({8'h12, 8'h80});
        serve(3, 1'b0, r0, d0);
        exp_q.push_back({8'h34, 8'h55});
        wait_req(ok, r0);
        repeat (TMO - 1) @(negedge clk);
        chk("c_no_error_before_timeout", 32'(error), 32'd0);
        @(negedge clk);
        chk("c_error_at_timeout", 32'(error), 32'd1);
        chk("c_err_index", 32'(err_index), 32'd1);
        chk("c_busy", 32'(busy), 32'd0);

        // wr_done on the final timeout cycle wins, then reset aborts during WAIT of index 3.
        pulse_start();
        exp_q.push_back({8'h12, 8'h80});
        serve(TMO - 1, 1'b0, r0, d0);
        @(negedge clk);
        chk("d_no_error_on_edge_done", 32'(error), 32'd0);
        exp_q.push_back({8'h34, 8'h55});
        serve(2, 1'b0, r0, d0);
        exp_q.push_back({8'h56, 8'h66});
        serve(2, 1'b0, r0, d0);
        exp_q.push_back({8'h77, 8'h88});
        wait_req(ok, r0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle_outputs("midreset");
        rc0 = req_cnt;
        repeat (10) @(negedge clk);
        chk("d_no_req_after_reset", 32'(req_cnt), 32'(rc0));

        // After reset the pass restarts at entry 0; then start and wr_done are ignored while busy.
        pulse_start();
        exp_q.push_back({8'h12, 8'h80});
        serve(4, 1'b0, r0, d0);
        wr_busy = 1'b1;
        rc0 = req_cnt;
        repeat (20) @(negedge clk);
        pulse_start();
        repeat (10) @(negedge clk);
        wr_done = 1'b1;
        @(negedge clk);
        wr_done = 1'b0;
        repeat (22) @(negedge clk);
        chk("f_busy_held", 32'(busy), 32'd1);
        chk("f_no_req_while_wr_busy", 32'(req_cnt), 32'(rc0));
        exp_q.push_back({8'h34, 8'h55});
        wr_busy = 1'b0;
        wait_req(ok, r0);
        @(negedge clk);
        chk("f_queue_empty", 32'(exp_q.size()), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
